// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 32-bit words into a prefetch FIFO and hands them to decode.
// Latency: a word acked in cycle N shows up at the FIFO head in cycle N+1.
// Backpressure: Instr_Ready_i gates pops, and no fetch is requested while the FIFO is full.
// Optional macro OPCODE_CHECK_EN adds Illegal_Op_o, which flags a head opcode outside the supported set.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  Imem_Req_o,
  output logic [ADDR_WIDTH-1:0] Imem_Addr_o,
  input  logic                  Imem_Ack_i,
  input  logic [31:0]           Imem_Data_i,
  input  logic                  Redirect_i,
  input  logic [ADDR_WIDTH-1:0] Redirect_PC_i,
  output logic                  Instr_Valid_o,
  input  logic                  Instr_Ready_i,
  output logic [31:0]           Instr_o,
  output logic [ADDR_WIDTH-1:0] PC_o,
  output logic [6:0]            OP_o
`ifdef OPCODE_CHECK_EN
  , output logic                Illegal_Op_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  typedef enum logic {S_FETCH, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [ADDR_WIDTH-1:0] mem_pc_q  [FIFO_DEPTH];
  logic [31:0]           mem_ins_q [FIFO_DEPTH];

  logic                  valid, ack, push, pop;
  logic [ADDR_WIDTH-1:0] redir_pc;

  assign redir_pc = Redirect_PC_i & ~ADDR_WIDTH'(3);
  assign valid    = (count_q != '0);
  assign ack      = req_q & Imem_Ack_i;
  // Redirect wins over both FIFO ports: the FIFO is cleared instead.
  assign push     = (state_q == S_FETCH) & ack & ~Redirect_i;
  assign pop      = valid & Instr_Ready_i & ~Redirect_i;

  // Next-state: FIFO pointers/count, fetch PC, redirect/flush sequencing and request.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    req_d        = req_q;

    if (push) begin
      wr_ptr_d   = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PTR_W'(1);
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (Redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (state_q == S_FLUSH) begin
        // Latest redirect replaces any earlier pending target.
        if (ack) begin
          fetch_pc_d = redir_pc;
          state_d    = S_FETCH;
        end else begin
          pending_pc_d = redir_pc;
        end
      end else if (req_q && !Imem_Ack_i) begin
        // Request in flight: keep it stable and drop its data when it returns.
        state_d      = S_FLUSH;
        pending_pc_d = redir_pc;
      end else begin
        fetch_pc_d = redir_pc;
      end
    end else if (state_q == S_FLUSH && ack) begin
      fetch_pc_d = pending_pc_q;
      state_d    = S_FETCH;
    end

    // A raised request stays up until acked; otherwise request whenever there is room.
    if (state_d == S_FLUSH) begin
      req_d = 1'b1;
    end else begin
      req_d = (count_d < DEPTH_C);
    end
  end

  // Control registers with synchronous reset; any outstanding request is abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      req_q        <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]  <= fetch_pc_q;
      mem_ins_q[wr_ptr_q] <= Imem_Data_i;
    end
  end

  assign Imem_Req_o    = req_q;
  assign Imem_Addr_o   = fetch_pc_q;
  assign Instr_Valid_o = valid;
  assign Instr_o       = valid ? mem_ins_q[rd_ptr_q] : NOP;
  assign PC_o          = valid ? mem_pc_q[rd_ptr_q] : '0;
  assign OP_o          = Instr_o[6:0];

`ifdef OPCODE_CHECK_EN
  logic op_legal;

  // Supported RV32I major opcodes.
  always_comb begin
    op_legal = 1'b0;
    case (OP_o)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0100011, 7'b0000011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign Illegal_Op_o = valid & ~op_legal;
`endif

endmodule
